// File: rtl/duty_ramp_if.sv
// ============================================================================
//  Module      : duty_ramp_if
//  Description : Control/status bundle for the duty_ramp block. The master
//                side issues load/target/hold and observes duty/busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface duty_ramp_if;
    logic        load;
    logic [10:0] target;
    logic        hold;
    logic [10:0] duty;
    logic        busy;
    logic        done;

    modport master (
        output load,
        output target,
        output hold,
        input  duty,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  target,
        input  hold,
        output duty,
        output busy,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/duty_ramp.sv
// ============================================================================
//  Module      : duty_ramp
//  Description : Ramps an 11-bit PWM duty value toward a latched target in
//                STEP increments, one step every PRESCALE clocks. Supports
//                retargeting at any time and a hold input that freezes it.
//                Optional macro DUTY_RAMP_LIMIT_EN clamps the latched
//                target to DUTY_LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module duty_ramp #(
    parameter int PRESCALE   = 512,     // clocks per duty step (2..4096)
    parameter int STEP       = 16,      // duty change per step (1..2047)
    parameter int DUTY_LIMIT = 11'h600  // target ceiling when limit enabled
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    duty_ramp_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    localparam logic [11:0]        c_CNT_MAX = 12'(PRESCALE - 1);
    localparam logic [11:0]        c_STEP_U  = 12'(STEP);
    localparam logic signed [12:0] c_STEP_S  = 13'(STEP);

    state_t      state_q, state_d;
    logic [10:0] duty_q,  duty_d;
    logic [10:0] tgt_q,   tgt_d;
    logic [11:0] cnt_q,   cnt_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    // Target value as it would be latched on a load edge.
    logic [10:0] w_tgt_load;

`ifdef DUTY_RAMP_LIMIT_EN
    localparam logic [10:0] c_LIMIT = 11'(DUTY_LIMIT);
    assign w_tgt_load = (bus.target > c_LIMIT) ? c_LIMIT : bus.target;
`else
    // The ceiling is unused in this build; fold it into a sink signal.
    logic w_unused_limit;
    assign w_unused_limit = ^(11'(DUTY_LIMIT));
    assign w_tgt_load     = bus.target;
`endif

    // Up step at 12 bits so the sum cannot wrap, then clamp to the target.
    logic [11:0] w_up_sum;
    logic [10:0] w_up_next;
    assign w_up_sum  = {1'b0, duty_q} + c_STEP_U;
    assign w_up_next = (w_up_sum > {1'b0, tgt_q}) ? tgt_q : w_up_sum[10:0];

    // Down step signed so a negative result is caught and clamped.
    logic signed [12:0] w_dn_diff;
    logic [10:0]        w_dn_next;
    assign w_dn_diff = $signed({2'b00, duty_q}) - c_STEP_S;
    assign w_dn_next = (w_dn_diff < $signed({2'b00, tgt_q})) ? tgt_q : w_dn_diff[10:0];

    logic [10:0] w_step_next;
    assign w_step_next = (state_q == S_UP) ? w_up_next : w_dn_next;

    // Next-state logic: load has top priority, then hold, then stepping.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (bus.load) begin
            tgt_d = w_tgt_load;
            cnt_d = 12'd0;
            if (w_tgt_load > duty_q) begin
                state_d = S_UP;
                busy_d  = 1'b1;
            end else if (w_tgt_load < duty_q) begin
                state_d = S_DOWN;
                busy_d  = 1'b1;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (!bus.hold) begin
            case (state_q)
                S_UP, S_DOWN: begin
                    if (cnt_q == c_CNT_MAX) begin
                        cnt_d  = 12'd0;
                        duty_d = w_step_next;
                        if (w_step_next == tgt_q) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 12'd0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            duty_q  <= 11'h000;
            tgt_q   <= 11'h000;
            cnt_q   <= 12'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.duty = duty_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_duty_ramp.sv
// ============================================================================
//  Module      : tb_duty_ramp
//  Description : Self-checking bench for duty_ramp with PRESCALE=4, STEP=16.
//                Per-cycle vector table plus hand-written limit and
//                reset-mid-ramp sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_duty_ramp;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    duty_ramp_if bus ();

    duty_ramp #(
        .PRESCALE (4),
        .STEP     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [10:0] tg;
        logic        hd;
        logic [10:0] ed;
        logic        eb;
        logic        edn;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ld, input logic [10:0] tg, input logic hd,
                       input logic [10:0] ed, input logic eb, input logic edn);
        vec_t v;
        v.ld = ld; v.tg = tg; v.hd = hd; v.ed = ed; v.eb = eb; v.edn = edn;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [10:0] ed,
                         input logic eb, input logic edn);
        checks++;
        if (bus.duty !== ed || bus.busy !== eb || bus.done !== edn) begin
            failures++;
            $display("FAIL %s: got duty=%h busy=%b done=%b, required duty=%h busy=%b done=%b",
                     name, bus.duty, bus.busy, bus.done, ed, eb, edn);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] lim_exp;
    logic [10:0] prev;
    bit          seen_done;
    bit          bad_step;

    initial begin
        checks   = 0;
        failures = 0;
        bus.load   = 1'b0;
        bus.target = 11'h000;
        bus.hold   = 1'b0;
        rst_n      = 1'b0;

        // ---------------- vector table ----------------
        // A: ramp up 0 -> 0x040
        add(1, 11'h040, 0, 11'h000, 1, 0);
        for (int k = 1; k <= 16; k++) add(0, 0, 0, 11'(16 * (k / 4)), k < 16, k == 16);
        add(0, 0, 0, 11'h040, 0, 0);
        // B: ramp down 0x040 -> 0
        add(1, 11'h000, 0, 11'h040, 1, 0);
        for (int k = 1; k <= 16; k++) add(0, 0, 0, 11'(64 - 16 * (k / 4)), k < 16, k == 16);
        add(0, 0, 0, 11'h000, 0, 0);
        // C: non-multiple target 0 -> 0x045
        add(1, 11'h045, 0, 11'h000, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            int d;
            d = 16 * (k / 4);
            if (d > 'h45) d = 'h45;
            add(0, 0, 0, 11'(d), k < 20, k == 20);
        end
        add(0, 0, 0, 11'h045, 0, 0);
        // D: load equal to current duty
        add(1, 11'h045, 0, 11'h045, 0, 1);
        add(0, 0, 0, 11'h045, 0, 0);
        // E: ramp down 0x045 -> 0, last step clamps at 0
        add(1, 11'h000, 0, 11'h045, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            int d;
            d = 'h45 - 16 * (k / 4);
            if (d < 0) d = 0;
            add(0, 0, 0, 11'(d), k < 20, k == 20);
        end
        add(0, 0, 0, 11'h000, 0, 0);
        // F: retarget 0x080 then 0 at duty 0x020, counter restarts
        add(1, 11'h080, 0, 11'h000, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 11'(16 * (k / 4)), 1, 0);
        add(1, 11'h000, 0, 11'h020, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 11'(32 - 16 * (k / 4)), k < 8, k == 8);
        add(0, 0, 0, 11'h000, 0, 0);
        // G: hold for 10 cycles mid-prescale
        add(1, 11'h040, 0, 11'h000, 1, 0);
        add(0, 0, 0, 11'h000, 1, 0);
        add(0, 0, 0, 11'h000, 1, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 1, 11'h000, 1, 0);
        for (int k = 1; k <= 14; k++) add(0, 0, 0, 11'(16 * ((k + 2) / 4)), k < 14, k == 14);
        add(0, 0, 0, 11'h040, 0, 0);
        // H: load coinciding with a step edge wins, then equal load while busy
        add(1, 11'h080, 0, 11'h040, 1, 0);
        for (int k = 1; k <= 3; k++) add(0, 0, 0, 11'h040, 1, 0);
        add(1, 11'h0C0, 0, 11'h040, 1, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 0, 11'(64 + 16 * (k / 4)), 1, 0);
        add(1, 11'h050, 0, 11'h050, 0, 1);
        add(0, 0, 0, 11'h050, 0, 0);
        // I: load accepted during hold, counter frozen until release
        add(1, 11'h060, 1, 11'h050, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 11'h050, 1, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 0, (k == 4) ? 11'h060 : 11'h050, k < 4, k == 4);
        add(0, 0, 0, 11'h060, 0, 0);

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 11'h000, 0, 0);
        rst_n = 1'b1;
        tick();
        check("after_reset_idle", 11'h000, 0, 0);

        // ---------------- apply table ----------------
        foreach (vq[i]) begin
            string nm;
            bus.load   = vq[i].ld;
            bus.target = vq[i].tg;
            bus.hold   = vq[i].hd;
            tick();
            nm = $sformatf("vec%0d", i);
            check(nm, vq[i].ed, vq[i].eb, vq[i].edn);
        end
        bus.load = 1'b0;
        bus.hold = 1'b0;

        // ---------------- limit sequence (from 0x060) ----------------
`ifdef DUTY_RAMP_LIMIT_EN
        lim_exp = 11'h600;
`else
        lim_exp = 11'h7FF;
`endif
        bus.load   = 1'b1;
        bus.target = 11'h7FF;
        tick();
        bus.load  = 1'b0;
        check("limit_start", 11'h060, 1, 0);
        seen_done = 0;
        bad_step  = 0;
        prev      = bus.duty;
        for (int c = 0; c < 2000 && !seen_done; c++) begin
            tick();
            if (bus.duty < prev || (bus.duty - prev) > 11'd16 || bus.duty > lim_exp) bad_step = 1;
            prev = bus.duty;
            if (bus.done) seen_done = 1;
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL limit_timeout: done not seen, duty=%h required done with duty=%h",
                     bus.duty, lim_exp);
        end
        checks++;
        if (bad_step) begin
            failures++;
            $display("FAIL limit_step: got an illegal duty step, required monotonic steps <= 16 not above %h",
                     lim_exp);
        end
        check("limit_final", lim_exp, 0, 1);
        tick();
        check("limit_idle", lim_exp, 0, 0);

        // ---------------- reset mid-ramp ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("rst2_idle", 11'h000, 0, 0);
        bus.load   = 1'b1;
        bus.target = 11'h040;
        tick();
        bus.load = 1'b0;
        repeat (12) tick();
        check("pre_reset_mid", 11'h030, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", 11'h000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_reset_wait", 11'h000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
